// File: rtl/sha2_pkg.sv
// Shared SHA-256 constants, state/FSM types and the sigma/choice/majority helpers.
// Working state and digests are packed with word 0 (a / H0) in the top 32 bits.
package sha2_pkg;

  typedef logic [7:0][31:0] sha2_state_t;
  typedef logic [1:0]       sha2_fsm_e;

  localparam sha2_fsm_e S_IDLE = 2'd0;
  localparam sha2_fsm_e S_RUN  = 2'd1;
  localparam sha2_fsm_e S_FEED = 2'd2;
  localparam sha2_fsm_e S_DONE = 2'd3;

  localparam sha2_state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Schedule sigmas: rotations written as constant slices.
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// Rolling 16-word message schedule window; slot 0 always holds W[r] for the current round.
// Loads the block on accept, shifts one word per round, appending W[r+16].
module sha2_msg_sched import sha2_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_block,
  output logic [31:0]  o_w_cur
);

  logic [31:0] r_win [0:15];
  logic [31:0] w_next;

  // Window holds W[r..r+15], so W[r+16] needs slots 14, 9, 1 and 0.
  assign w_next = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) r_win[i] <= i_block[511 - 32*i -: 32];
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_next;
    end
  end

  assign o_w_cur = r_win[0];

endmodule

// File: rtl/sha2_round.sv
// One combinational SHA-256 round: working state a..h plus K[round] and W -> next a..h.
// No storage; the controller registers the result.
module sha2_round import sha2_pkg::*; (
  input  logic [5:0]   i_round,
  input  logic [31:0]  i_w,
  input  logic [255:0] i_state,
  output logic [255:0] o_state
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

  assign w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + K[i_round] + i_w;
  assign w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);

  assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha2_compress_ctrl.sv
// Iterative SHA-256 compression: one round per clock, then feed-forward, digest held until out_ready.
// Accepts only in IDLE or in DONE during the output handshake; in_valid is ignored while busy.
module sha2_compress_ctrl import sha2_pkg::*; #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] state_in,
  input  logic         use_iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  sha2_fsm_e    r_state;
  logic [5:0]   r_round;
  logic [255:0] r_h_in;
  logic [255:0] r_work;
  logic [255:0] r_digest;
  logic         r_out_vld;

  logic         w_accept;
  logic         w_last;
  logic [255:0] w_init;
  logic [255:0] w_round_out;
  logic [255:0] w_feed;
  logic [31:0]  w_w_cur;

  assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_round == LAST_ROUND);
  assign w_init   = use_iv ? IV : state_in;

  sha2_msg_sched u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (r_state == S_RUN),
    .i_block (block_in),
    .o_w_cur (w_w_cur)
  );

  sha2_round u_round (
    .i_round (r_round),
    .i_w     (w_w_cur),
    .i_state (r_work),
    .o_state (w_round_out)
  );

  // Feed-forward adds are per word; carries must not cross word boundaries.
  for (genvar g = 0; g < 8; g++) begin : g_feed
    assign w_feed[32*g +: 32] = r_h_in[32*g +: 32] + r_work[32*g +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_round   <= '0;
      r_h_in    <= '0;
      r_work    <= '0;
      r_digest  <= '0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_work  <= w_round_out;
          r_round <= r_round + 6'd1;
          if (w_last) r_state <= S_FEED;
        end
        S_FEED: begin
          r_digest  <= w_feed;
          r_out_vld <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // An accept (IDLE, or DONE during handshake) overrides the state update above.
      if (w_accept) begin
        r_state <= S_RUN;
        r_h_in  <= w_init;
        r_work  <= w_init;
        r_round <= '0;
      end
    end
  end

  assign out_valid  = r_out_vld;
  assign digest_out = r_digest;
  assign busy       = (r_state == S_RUN) | (r_state == S_FEED);

endmodule
